// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
   localparam int XLEN = 16;
   localparam logic [XLEN-1:0] NOP_DEFAULT = 16'h0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO holding {pc, instr} pairs; clear has priority.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clear,
   input  logic [W-1:0]               din,
   output logic [$clog2(DEPTH):0]     count,
   output logic [W-1:0]               head
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (clear) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr] <= din;
   end

   assign head = mem[rd_ptr];
endmodule

// File: rtl/ifetch_stage.sv
// Fetch stage: single-outstanding imem requests, response queue feeding decode,
// PC stall generation and flush handling.
module ifetch_stage
   import fetch_pkg::*;
#(
   parameter int              DEPTH     = 2,
   parameter logic [XLEN-1:0] NOP_INSTR = NOP_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr,
   input  logic        flush,
   input  logic        id_stall,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [15:0] imem_rdata,
   output logic        fetch_stall,
   output logic        valid_IM_ID,
   output logic [15:0] instr_IM_ID,
   output logic [15:0] pc_IM_ID
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   fetch_state_t     state, state_nxt;
   logic [XLEN-1:0]  req_pc;
   logic [AW:0]      count;
   logic [2*XLEN-1:0] head;
   logic             issue, push, pop;

   fetch_fifo #(.DEPTH(DEPTH), .W(2*XLEN)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .clear (flush),
      .din   ({req_pc, imem_rdata}),
      .count (count),
      .head  (head)
   );

   assign issue       = (state == IDLE) && !rst && !flush && (count < CNT_FULL);
   assign push        = (state == WAIT) && imem_rvalid && !flush;
   assign valid_IM_ID = (count != '0) && !flush && !rst;
   assign pop         = valid_IM_ID && !id_stall;

   assign imem_req    = issue;
   assign imem_addr   = addr;
   // Released on flush so the PC can load the branch target despite stall priority.
   assign fetch_stall = rst || !(issue || flush);
   assign instr_IM_ID = valid_IM_ID ? head[XLEN-1:0]      : NOP_INSTR;
   assign pc_IM_ID    = valid_IM_ID ? head[2*XLEN-1:XLEN] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         req_pc <= '0;
      end else begin
         state <= state_nxt;
         if (issue) req_pc <= addr;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (issue) state_nxt = WAIT;
         WAIT: begin
            if (imem_rvalid)  state_nxt = IDLE;
            else if (flush)   state_nxt = DROP;
         end
         DROP: if (imem_rvalid) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_ifetch_stage.sv
// Randomized bench: variable-latency memory, random stalls/flushes/resets,
// outputs compared each cycle against a queue-based reference model.
module tb_ifetch_stage;
   localparam int DEPTH = 2;
   localparam logic [15:0] NOP = 16'h0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addr;
   logic        flush, id_stall;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_rvalid;
   logic [15:0] imem_rdata;
   logic        fetch_stall, valid_IM_ID;
   logic [15:0] instr_IM_ID, pc_IM_ID;

   ifetch_stage #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
      .clk         (clk),
      .rst         (rst),
      .addr        (addr),
      .flush       (flush),
      .id_stall    (id_stall),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .fetch_stall (fetch_stall),
      .valid_IM_ID (valid_IM_ID),
      .instr_IM_ID (instr_IM_ID),
      .pc_IM_ID    (pc_IM_ID)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
   endtask

   // Reference model: decoded-pair queue plus the fate of the one outstanding fetch.
   logic [31:0] q[$];
   int          outstanding;   // 0 none, 1 will be delivered, 2 will be discarded
   logic [15:0] out_pc;

   // Memory environment
   bit          mem_busy;
   int          mem_wait;

   initial begin
      bit exp_issue, exp_valid;
      int stall_burst;
      q.delete();
      outstanding = 0;
      out_pc      = '0;
      mem_busy    = 0;
      mem_wait    = 0;
      stall_burst = 0;
      rst = 1'b1; addr = '0; flush = 1'b0; id_stall = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = '0;

      for (int cyc = 0; cyc < 4000; cyc++) begin
         // ---- drive this cycle's inputs
         if (cyc < 3) rst = 1'b1;
         else rst = ($urandom_range(0, 199) == 0);
         addr  = (cyc == 3) ? 16'h0000 : 16'($urandom);
         flush = ($urandom_range(0, 14) == 0);
         if (stall_burst > 0) stall_burst--;
         else if ($urandom_range(0, 19) == 0) stall_burst = $urandom_range(2, 8);
         id_stall = (stall_burst > 0) || ($urandom_range(0, 4) == 0);
         imem_rdata = 16'($urandom);
         if (mem_busy && mem_wait == 0) imem_rvalid = 1'b1;
         else if (!mem_busy && outstanding == 0) imem_rvalid = ($urandom_range(0, 9) == 0);
         else imem_rvalid = 1'b0;

         @(negedge clk);
         // ---- compare against model
         if (rst) begin
            chk("rst_req",   imem_req,    1'b0);
            chk("rst_stall", fetch_stall, 1'b1);
            chk("rst_valid", valid_IM_ID, 1'b0);
            chk("rst_instr", instr_IM_ID, NOP);
            chk("rst_pc",    pc_IM_ID,    16'h0);
         end else begin
            exp_issue = (outstanding == 0) && !flush && (q.size() < DEPTH);
            exp_valid = (q.size() > 0) && !flush;
            chk("req",   imem_req,    exp_issue);
            chk("stall", fetch_stall, !(exp_issue || flush));
            chk("valid", valid_IM_ID, exp_valid);
            if (exp_issue) chk("req_addr", imem_addr, addr);
            chk("instr", instr_IM_ID, exp_valid ? q[0][15:0]  : NOP);
            chk("pc",    pc_IM_ID,    exp_valid ? q[0][31:16] : 16'h0);
         end

         // ---- memory reacts to what the DUT actually did
         if (imem_rvalid) mem_busy = 0;
         else if (mem_busy) mem_wait--;
         if (imem_req) begin
            mem_busy = 1;
            mem_wait = $urandom_range(0, 3);
         end

         // ---- model next state
         if (rst) begin
            q.delete();
            outstanding = 0;
         end else if (flush) begin
            q.delete();
            if (imem_rvalid) outstanding = 0;
            else if (outstanding != 0) outstanding = 2;
         end else begin
            if (exp_valid && !id_stall) void'(q.pop_front());
            if (imem_rvalid && outstanding == 1) q.push_back({out_pc, imem_rdata});
            if (imem_rvalid) outstanding = 0;
            if (exp_issue) begin
               outstanding = 1;
               out_pc      = addr;
            end
         end
         if (q.size() > DEPTH) chk("overflow", q.size(), DEPTH);

         @(posedge clk);
         #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction-fetch stage sitting directly downstream of the program-counter block and upstream of decode. It takes the current fetch address, issues single-outstanding requests to a variable-latency instruction memory, and buffers the returned {pc, instruction} pairs in a small queue. It presents the queue head to decode as the IM/ID pipeline payload. It drives the PC block's `stall` input so the PC advances only when a fetch is actually issued, and discards all in-flight and queued work on a control-flow change.

## Interface
Parameters:
- `DEPTH`, 2: instruction queue entries (power of two, ≥2).
- `NOP_INSTR`, 16'h0000: value driven on `instr_IM_ID` when the queue is empty.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `addr`  in  16  fetch address from the PC block.
- `flush`  in  1  control-flow change (`flow_change_ID_EX`); kills queue and outstanding fetch.
- `id_stall`  in  1  decode cannot accept this cycle.
- `imem_req`  out  1  request valid to instruction memory.
- `imem_addr`  out  16  request address (= `addr`).
- `imem_rvalid`  in  1  response valid; ≥1 cycle after request.
- `imem_rdata`  in  16  response instruction.
- `fetch_stall`  out  1  to PC `stall`; 0 only in cycles where the PC may advance.
- `valid_IM_ID`  out  1  queue head valid to decode.
- `instr_IM_ID`  out  16  queue head instruction, else `NOP_INSTR`.
- `pc_IM_ID`  out  16  queue head pc, else 0.

## Operation
- FSM states: IDLE, WAIT, DROP; registers `req_pc[15:0]`, queue (`count`, `rd_ptr`, `wr_ptr`).
- IDLE: issue = ~rst & ~flush & (count < DEPTH). On issue: `imem_req`=1, `imem_addr`=`addr`, latch `req_pc`=`addr`, go WAIT.
- WAIT: `imem_req`=0. On `imem_rvalid` & ~flush: push {`req_pc`, `imem_rdata`}, go IDLE. On `imem_rvalid` & flush: discard, go IDLE. On flush & ~`imem_rvalid`: go DROP.
- DROP: on `imem_rvalid` discard, go IDLE. Flush in DROP: stay DROP.
- `fetch_stall` = ~(issue | flush). It is forced 0 on flush so the PC loads the branch target, because the PC gives stall priority over flow change.
- Pop when `valid_IM_ID` & ~`id_stall`. Simultaneous push and pop: count unchanged, both pointers advance.
- `valid_IM_ID` = (count ≠ 0) & ~flush.
- Flush clears the queue at the next edge (count, pointers ← 0). A push in the same cycle is suppressed.
- Overflow is impossible by construction: issue requires count < DEPTH, and there is one outstanding request at most. The bench asserts this.

## Timing
- Request in cycle t, `imem_rvalid` in cycle t+k (k≥1): the entry is visible at the head in cycle t+k+1.
- Back-to-back issue is possible the cycle after a response. Peak throughput is one fetch per k+1 cycles.
- Reset values: state IDLE, count/pointers 0, `req_pc` 0. While `rst` is high: `imem_req` 0, `fetch_stall` 1, `valid_IM_ID` 0, `instr_IM_ID` `NOP_INSTR`, `pc_IM_ID` 0.
- Reset mid-WAIT abandons the request. A late `imem_rvalid` arriving in IDLE after reset is ignored.
- `imem_rvalid` in IDLE is always ignored.

## Structure
- Shared package `fetch_pkg`: state enum (IDLE/WAIT/DROP), `XLEN`=16, default `NOP_INSTR`.
- Sub-module `fetch_fifo`: DEPTH × 32-bit synchronous FIFO with push, pop, clear, count and head outputs.
- The FSM and handshake logic live in `ifetch_stage`.

## Test plan
- Reset: assert `rst` mid-operation → `valid_IM_ID`=0, `imem_req`=0, `fetch_stall`=1, `instr_IM_ID`=`NOP_INSTR`. Release with `addr`=0x0000 → `imem_req`=1, `imem_addr`=0x0000, `fetch_stall`=0.
- Streaming, k=1, `id_stall`=0: addrs 0x0000, 0x0001, 0x0002 with data 0xA000, 0xA001, 0xA002 → head shows pc/instr pairs in order, each valid 2 cycles after its request.
- Backpressure: hold `id_stall`=1 → after 2 pushes count=2, `imem_req` stays 0 and `fetch_stall` 1. Release → pops 0x0000 then 0x0001, and issue resumes the cycle count drops below 2.
- Flush in WAIT, k=3, `addr`=0x0040 at flush: `fetch_stall`=0 in the flush cycle, FSM goes to DROP, the late response is not pushed, and the next request uses `imem_addr`=0x0040.
- Flush coincident with `imem_rvalid` and a non-empty queue → response discarded, count=0 next cycle, `valid_IM_ID`=0 during the flush cycle.
- Simultaneous push/pop at count=1 → count stays 1 and the head advances to the newly pushed entry.
